// File: rtl/edge_count_scheduler.sv
// rtl/edge_count_scheduler.sv - multi-channel rising-edge counter with one shared
// round-robin-scheduled increment/decrement unit
module edge_count_scheduler #(
   parameter int N_CH  = 4,
   parameter int CNT_W = 2,
   parameter int ID_W  = $clog2(N_CH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_CH-1:0]         state,
   input  logic [N_CH-1:0]         dir,
   input  logic                    en,
   input  logic                    clr_lost,
   output logic [N_CH*CNT_W-1:0]   counts,
   output logic [N_CH-1:0]         pending,
   output logic                    grant_valid,
   output logic [ID_W-1:0]         grant_id,
   output logic [N_CH-1:0]         lost
);

   logic [N_CH-1:0]       prev_q;
   logic [N_CH-1:0]       pending_q, pending_d;
   logic [N_CH-1:0]       lost_q, lost_d;
   logic [N_CH*CNT_W-1:0] counts_q, counts_d;
   logic [ID_W-1:0]       ptr_q, ptr_d;
   logic                  grant_valid_q, grant_valid_d;
   logic [ID_W-1:0]       grant_id_q, grant_id_d;

   logic [N_CH-1:0]       rise_w;
   logic [N_CH-1:0]       gnt_mask;
   logic                  gnt_found;
   logic [ID_W-1:0]       gnt_id;
   logic                  grant;
   logic [CNT_W-1:0]      cur_cnt;

   // Round-robin search starts one past the last granted channel
   always_comb begin
      gnt_found = 1'b0;
      gnt_id    = '0;
      for (int k = 1; k <= N_CH; k++) begin
         if (!gnt_found && pending_q[(int'(ptr_q) + k) % N_CH]) begin
            gnt_found = 1'b1;
            gnt_id    = ID_W'((int'(ptr_q) + k) % N_CH);
         end
      end
   end

   assign grant  = en & gnt_found;
   assign rise_w = state & ~prev_q;

   always_comb begin
      gnt_mask = '0;
      if (grant) gnt_mask[gnt_id] = 1'b1;

      // A fresh edge on the channel being granted re-arms it instead of being lost
      pending_d = (pending_q & ~gnt_mask) | rise_w;
      lost_d    = (clr_lost ? '0 : lost_q) | (rise_w & pending_q & ~gnt_mask);

      counts_d = counts_q;
      cur_cnt  = counts_q[int'(gnt_id)*CNT_W +: CNT_W];
      if (grant) begin
         counts_d[int'(gnt_id)*CNT_W +: CNT_W] = dir[gnt_id] ? cur_cnt + CNT_W'(1)
                                                            : cur_cnt - CNT_W'(1);
      end

      ptr_d         = grant ? gnt_id : ptr_q;
      grant_valid_d = grant;
      grant_id_d    = grant ? gnt_id : grant_id_q;
   end

   always_ff @(posedge clk) begin
      prev_q <= state;
      if (rst) begin
         pending_q     <= '0;
         lost_q        <= '0;
         counts_q      <= '0;
         ptr_q         <= ID_W'(N_CH - 1);
         grant_valid_q <= 1'b0;
         grant_id_q    <= '0;
      end else begin
         pending_q     <= pending_d;
         lost_q        <= lost_d;
         counts_q      <= counts_d;
         ptr_q         <= ptr_d;
         grant_valid_q <= grant_valid_d;
         grant_id_q    <= grant_id_d;
      end
   end

   assign counts      = counts_q;
   assign pending     = pending_q;
   assign lost        = lost_q;
   assign grant_valid = grant_valid_q;
   assign grant_id    = grant_id_q;

endmodule

// File: doc/edge_count_scheduler.md
Name: edge_count_scheduler

Overview:
- Multi-channel rising-edge event counter. One shared increment/decrement unit, time-shared across N_CH spike/state inputs.
- Each channel detects rising edges on its `state` line and latches a pending request. A round-robin arbiter grants one channel per cycle to the shared unit, which updates that channel's wrapping CNT_W-bit count.
- Sits between the neuron spike outputs and the readout/monitor logic. Replaces per-channel free-running toggle counters.

Parameters:
- N_CH, 4, number of input channels (>=2).
- CNT_W, 2, width of each channel count; modulo-2^CNT_W wrap.
- ID_W, $clog2(N_CH), width of grant_id.

Ports:
- clk  input  1  single system clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- state  input  N_CH  per-channel level input, synchronous to clk; rising edge = one event.
- dir  input  N_CH  per-channel direction sampled at grant: 1 = +1, 0 = -1.
- en  input  1  arbiter enable; 0 = no grants, pending requests held.
- clr_lost  input  1  clears all lost flags (1-cycle pulse).
- counts  output  N_CH*CNT_W  flattened counts, channel i at [i*CNT_W +: CNT_W], registered.
- pending  output  N_CH  registered pending-request flags.
- grant_valid  output  1  registered; 1 for the cycle after a count update.
- grant_id  output  ID_W  registered; channel updated, valid when grant_valid=1.
- lost  output  N_CH  sticky flag: an edge was dropped because the request was already pending.

Behaviour:
- Reset (rst=1 at posedge):
  - counts=0, pending=0, lost=0, grant_valid=0, grant_id=0.
  - RR pointer = N_CH-1, so channel 0 has top priority first.
  - prev_state <= state, so an input already high at reset release produces no edge.
  - Reset mid-operation discards all pending events. Reset overrides en and clr_lost.
- Edge detect: edge[i] = state[i] & ~prev_state[i]. prev_state <= state every cycle.
- Arbitration:
  - Combinational, over the registered pending vector.
  - Search order starts at ptr+1, wraps modulo N_CH, and picks the first set bit.
  - A grant occurs when en=1 and |pending.
- On grant of channel g at posedge:
  - count[g] <= count[g] + 1 if dir[g]=1, else count[g] - 1.
  - Arithmetic is modulo 2^CNT_W: max+1 wraps to 0; 0-1 wraps to max.
  - pending[g] cleared, ptr <= g, grant_valid <= 1, grant_id <= g.
- No grant: grant_valid <= 0; grant_id and ptr hold.
- Pending update per channel, evaluated the same posedge:
  - Granted this cycle and edge this cycle: pending stays 1 (set wins). No loss.
  - Not granted, pending already 1, edge this cycle: pending stays 1, lost[i] <= 1.
  - Otherwise: pending <= pending | edge.
- lost clearing:
  - clr_lost=1 clears all lost bits.
  - If a new loss occurs in the same cycle, that bit is set (set wins over clear).
- Latency: state[i] first sampled high at posedge k gives pending[i]=1 after k. With en=1 and no contention, the count updates at posedge k+1 and grant_valid=1 during cycle k+1..k+2.
- Throughput: at most one count update per cycle, total. Each channel is served within N_CH cycles of its request while en=1 (starvation-free).
- en=0: edges still detected and pending/lost still updated; counts frozen.
- A held-high state produces exactly one event; it must return low for at least 1 cycle before re-triggering.

Test Plan:
- Reset release with state=4'b0101 held high, then 3 idle cycles -> no pending, no grant_valid, counts all 0.
- Ch1: state rises at posedge k, dir[1]=1 -> pending[1]=1 after k; count1 goes 0->1 at k+1; grant_valid=1, grant_id=1. Repeat 3 more times -> count1 goes 2, 3, then wraps to 0.
- dir[2]=0, single edge on ch2 from reset -> count2 goes 0 -> 3 (wrap down).
- All 4 channels rise in the same cycle with en=1 -> grants in 4 consecutive cycles, order 0,1,2,3. Next simultaneous burst after ptr=3 -> order 0,1,2,3 again. Each count = 1, then 2.
- en=0, ch3 pulses twice (rise, low, rise) -> count3 unchanged, pending[3]=1, lost[3]=1. Raise en -> count3 +1 only. Pulse clr_lost -> lost=0.
- Ch0 granted in the same cycle a new ch0 edge arrives -> pending[0] stays 1, lost[0]=0, second grant follows; count0 +2 total. Assert rst while pending=4'b1111 -> everything cleared next cycle, no further grants.
